// File: rtl/led_scan_mux.sv
// Time-multiplexes four BCD digits onto the LED decoder one digit per SCAN_DIV clocks,
// snapshotting all digits at each frame boundary so a mid-frame update cannot tear the display.
module led_scan_mux #(
  parameter int          SCAN_DIV   = 50000,
  parameter logic [3:0]  BLANK_CODE = 4'hF
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       en,
  input  logic       lz_blank,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  output logic [3:0] num_in,
  output logic [1:0] ctrl_led,
  output logic       frame_tick
);

  localparam int             DW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] r_divCnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_snap;
  logic [3:0]    r_numIn;
  logic [1:0]    r_ctrlLed;
  logic          r_frameTick;

  logic [15:0]   w_live;
  logic          w_step;
  logic          w_boundary;
  logic [1:0]    w_nextIdx;
  logic [3:0]    w_nextCode;

  // Digit j is a leading zero when it and every more-significant digit of the same source are 0
  function automatic logic [3:0] codeFor(input logic [1:0] j, input logic [15:0] src,
                                         input logic lz);
    logic [3:0] v;
    logic       allZero;
    v       = src[int'(j)*4 +: 4];
    allZero = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k >= int'(j) && src[k*4 +: 4] != 4'd0) allZero = 1'b0;
    end
    if (v > 4'd9)                          return BLANK_CODE;
    else if (lz && j != 2'd0 && allZero)   return BLANK_CODE;
    else                                   return v;
  endfunction

  assign w_live     = {digit3, digit2, digit1, digit0};
  assign w_step     = en && (r_divCnt == DIV_LAST);
  assign w_boundary = (r_idx == 2'd3);
  assign w_nextIdx  = r_idx + 2'd1;

  // The boundary step shows digit 0 straight from the live inputs being snapshotted on that edge
  always_comb begin
    w_nextCode = BLANK_CODE;
    if (w_boundary) w_nextCode = codeFor(2'd0, w_live, lz_blank);
    else            w_nextCode = codeFor(w_nextIdx, r_snap, lz_blank);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_divCnt    <= '0;
      r_idx       <= 2'd3;
      r_snap      <= '0;
      r_ctrlLed   <= 2'd0;
      r_numIn     <= BLANK_CODE;
      r_frameTick <= 1'b0;
    end else begin
      r_frameTick <= 1'b0;
      if (w_step) begin
        r_divCnt  <= '0;
        r_idx     <= w_nextIdx;
        r_ctrlLed <= w_nextIdx;
        r_numIn   <= w_nextCode;
        if (w_boundary) begin
          r_snap      <= w_live;
          r_frameTick <= 1'b1;
        end
      end else if (en) begin
        r_divCnt <= r_divCnt + DW'(1);
      end
    end
  end

  assign num_in     = r_numIn;
  assign ctrl_led   = r_ctrlLed;
  assign frame_tick = r_frameTick;

endmodule

// File: tb/tb_led_scan_mux.sv
// Scoreboard bench for led_scan_mux: stimulus queues expected scan steps, a negedge monitor
// detects each step the DUT presents and checks digit, code, frame tick and dwell length.
module tb_led_scan_mux;

  localparam int SCAN_DIV = 4;

  typedef struct {
    logic [1:0] ctrl;
    logic [3:0] num;
    logic       tick;
    string      name;
  } expItem_t;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       en;
  logic       lz_blank;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [3:0] num_in;
  logic [1:0] ctrl_led;
  logic       frame_tick;

  expItem_t   scoreQ[$];
  expItem_t   curExp;
  int         checkCount = 0;
  int         passCount  = 0;
  int         stimFails  = 0;
  int         enCount    = 0;
  logic       posRst     = 1'b0;
  logic       posEn      = 1'b0;
  logic [1:0] prevCtrl   = 2'd0;
  logic [3:0] prevNum    = 4'hF;

  led_scan_mux #(.SCAN_DIV(SCAN_DIV), .BLANK_CODE(4'hF)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .lz_blank(lz_blank),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .num_in(num_in), .ctrl_led(ctrl_led), .frame_tick(frame_tick)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Remember what the DUT saw on each rising edge so the monitor can count enabled clocks
  always @(posedge sys_clk) begin
    posRst <= !sys_rst_n;
    posEn  <= en;
  end

  task automatic checkOutput(input string name, input logic [1:0] expCtrl,
                             input logic [3:0] expNum, input logic expTick, input int expDwell);
    checkCount++;
    if (ctrl_led === expCtrl && num_in === expNum && frame_tick === expTick &&
        enCount == expDwell) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got ctrl=%0d num=%h tick=%b dwell=%0d, want ctrl=%0d num=%h tick=%b dwell=%0d",
               name, ctrl_led, num_in, frame_tick, enCount, expCtrl, expNum, expTick, expDwell);
    end
  endtask

  // A step is any change of digit select or code, or a frame tick; reset edges are checked separately
  always @(negedge sys_clk) begin
    if (posRst) begin
      enCount = 0;
      checkOutput("reset_state", 2'd0, 4'hF, 1'b0, 0);
    end else begin
      if (posEn) enCount++;
      if (ctrl_led !== prevCtrl || num_in !== prevNum || frame_tick !== 1'b0) begin
        if (scoreQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL unexpected_step: got ctrl=%0d num=%h tick=%b, want no step",
                   ctrl_led, num_in, frame_tick);
        end else begin
          curExp = scoreQ.pop_front();
          checkOutput(curExp.name, curExp.ctrl, curExp.num, curExp.tick, SCAN_DIV);
        end
        enCount = 0;
      end
    end
    prevCtrl = ctrl_led;
    prevNum  = num_in;
  end

  task automatic tickN(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                               input logic [3:0] d0, input logic lz);
    digit3   = d3;
    digit2   = d2;
    digit1   = d1;
    digit0   = d0;
    lz_blank = lz;
  endtask

  task automatic pushFrame(input string tag, input logic [3:0] n0, input logic [3:0] n1,
                           input logic [3:0] n2, input logic [3:0] n3);
    scoreQ.push_back('{ctrl: 2'd0, num: n0, tick: 1'b1, name: {tag, "_d0"}});
    scoreQ.push_back('{ctrl: 2'd1, num: n1, tick: 1'b0, name: {tag, "_d1"}});
    scoreQ.push_back('{ctrl: 2'd2, num: n2, tick: 1'b0, name: {tag, "_d2"}});
    scoreQ.push_back('{ctrl: 2'd3, num: n3, tick: 1'b0, name: {tag, "_d3"}});
  endtask

  task automatic drainQueue(input string tag);
    int n = 0;
    while (scoreQ.size() != 0 && n < 60) begin
      tickN(1);
      n++;
    end
    if (scoreQ.size() != 0) begin
      stimFails++;
      $display("[TB] FAIL %s_timeout: got %0d steps still pending, want 0", tag, scoreQ.size());
      scoreQ.delete();
    end
  endtask

  task automatic waitCtrl(input logic [1:0] target);
    int n = 0;
    while (ctrl_led !== target && n < 40) begin
      tickN(1);
      n++;
    end
    if (ctrl_led !== target) begin
      stimFails++;
      $display("[TB] FAIL wait_ctrl_timeout: got ctrl=%0d, want %0d", ctrl_led, target);
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    en        = 1'b1;
    applyStimulus(4'd4, 4'd3, 4'd2, 4'd1, 1'b0);
    pushFrame("first", 4'd1, 4'd2, 4'd3, 4'd4);
    tickN(3);
    sys_rst_n = 1'b1;
    drainQueue("first");

    applyStimulus(4'd0, 4'd0, 4'd0, 4'd5, 1'b1);
    pushFrame("lz_0005", 4'd5, 4'hF, 4'hF, 4'hF);
    drainQueue("lz_0005");

    applyStimulus(4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    pushFrame("lz_0000", 4'd0, 4'hF, 4'hF, 4'hF);
    drainQueue("lz_0000");

    applyStimulus(4'd0, 4'd1, 4'd0, 4'd0, 1'b1);
    pushFrame("lz_0100", 4'd0, 4'd0, 4'd1, 4'hF);
    drainQueue("lz_0100");

    applyStimulus(4'd0, 4'd0, 4'd0, 4'd5, 1'b0);
    pushFrame("nolz_0005", 4'd5, 4'd0, 4'd0, 4'd0);
    drainQueue("nolz_0005");

    applyStimulus(4'd9, 4'd8, 4'hC, 4'd1, 1'b1);
    pushFrame("badbcd", 4'd1, 4'hF, 4'd8, 4'd9);
    drainQueue("badbcd");

    applyStimulus(4'd0, 4'd3, 4'd2, 4'd1, 1'b0);
    pushFrame("tear", 4'd1, 4'd2, 4'd3, 4'd0);
    waitCtrl(2'd1);
    digit2 = 4'd7;
    drainQueue("tear");

    pushFrame("after_tear", 4'd1, 4'd2, 4'd7, 4'd0);
    drainQueue("after_tear");

    pushFrame("pause", 4'd1, 4'd2, 4'd7, 4'd0);
    waitCtrl(2'd2);
    en = 1'b0;
    tickN(10);
    en = 1'b1;
    drainQueue("pause");

    applyStimulus(4'd4, 4'd3, 4'd2, 4'd1, 1'b0);
    pushFrame("pre_reset", 4'd1, 4'd2, 4'd3, 4'd4);
    drainQueue("pre_reset");
    sys_rst_n = 1'b0;
    tickN(1);
    applyStimulus(4'd8, 4'd7, 4'd6, 4'd5, 1'b0);
    pushFrame("post_reset", 4'd5, 4'd6, 4'd7, 4'd8);
    sys_rst_n = 1'b1;
    drainQueue("post_reset");

    tickN(2);
    $display("%0d/%0d checks passed", passCount, checkCount + stimFails);
    $finish;
  end

endmodule
